cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Miss/write-through sequencer for the cache stage of the pipeline. It watches the access currently held in the cache stage pipeline register. On a load miss it stalls the pipeline and fetches the full line from memory word by word, writing each word into the data array and then the tag. On a store it holds the pipeline until the write-through to memory is acknowledged. Its `stall` output gates `enable_cache` and all upstream stage enables.

## Interface

Parameters:
- `ADDR_W`, 16, word-address width (matches the 16-bit datapath)
- `LINE_WORDS`, 4, words per line; power of two, ≥2; `OFF = log2(LINE_WORDS)`

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in 1: cache stage holds a memory access
- `req_we` in 1: access is a store
- `req_addr` in ADDR_W: word address of the access
- `req_wdata` in 16: store data
- `hit` in 1: tag/valid compare result for `req_addr`, combinational, same cycle
- `stall` out 1: freeze pipeline (`enable_cache = ~stall`)
- `mem_req` out 1: memory request, held until acknowledged
- `mem_we` out 1: request is a write
- `mem_addr` out ADDR_W: request address
- `mem_wdata` out 16: write data
- `mem_ack` in 1: memory accepts or returns one word this cycle
- `mem_rdata` in 16: read word, valid when `mem_ack`=1 on a read
- `fill_we` out 1: write `fill_data` into the data array at `fill_addr`
- `fill_addr` out ADDR_W: line base + word index
- `fill_data` out 16: equals `mem_rdata`
- `tag_we` out 1: write tag/valid for the captured line

## Operation

- States: IDLE, FILL, WRITE, DONE.
- **IDLE**:
  - `req_valid & ~req_we & ~hit` → FILL. Capture `base = {req_addr[ADDR_W-1:OFF], OFF'b0}` and clear the word index.
  - `req_valid & req_we` → WRITE. Capture `req_addr` and `req_wdata`; hit or miss makes no difference (no write allocate).
  - Otherwise stay in IDLE.
- **FILL**:
  - `mem_req=1`, `mem_we=0`, `mem_addr = base | idx`.
  - On `mem_ack`: pulse `fill_we` with `fill_addr = base | idx` and `fill_data = mem_rdata`, then increment `idx`.
  - Ack with `idx = LINE_WORDS-1`: also pulse `tag_we` that cycle → DONE. `idx` wraps to 0.
- **WRITE**:
  - `mem_req=1`, `mem_we=1`, `mem_addr` and `mem_wdata` driven from the captured values.
  - On `mem_ack` → DONE.
  - The datapath handles a store hit's data-array update; this block does not.
- **DONE**: `stall=0` unconditionally for exactly one cycle so the held access advances (a load re-reads and hits) → IDLE.
- `stall = (IDLE & req_valid & (req_we | ~hit)) | FILL | WRITE`. It is combinational, so the miss cycle itself is frozen.
- Captured address and data drive the memory side. Changes on `req_*` after capture are ignored.
- Reset (asynchronous, active-low):
  - state = IDLE, `idx = 0`.
  - All outputs are 0 while reset is asserted, including mid-FILL and mid-WRITE. Any in-flight memory request is abandoned.
  - No partial `tag_we` is ever issued, so a partially filled line is never marked valid.

## Timing

- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable from assertion until the cycle `mem_ack`=1 is sampled.
  - `mem_addr` advances the cycle after each ack.
  - `mem_req` stays high continuously across all words of a fill.
- Ack already high in the first FILL cycle: a word is transferred in that cycle.
- Minimum miss penalty: 1 (miss cycle) + LINE_WORDS + 1 (DONE) cycles. With ack tied high and `LINE_WORDS`=4, `stall` is high for 5 cycles.
- Minimum store penalty: 1 + 1, then DONE.
- `mem_ack` outside FILL or WRITE is ignored.
- `fill_we` and `tag_we` are single-cycle pulses coincident with the ack. `tag_we` appears only with the last word.

## Structure

- Shared package `cache_pkg`:
  - state encoding (IDLE=0, FILL=1, WRITE=2, DONE=3)
  - `LINE_WORDS` default and the `OFF` derivation
- Sub-module `fill_counter`: an OFF-bit word index with clear, increment on ack and a `last` flag (`idx == LINE_WORDS-1`).
- Outputs from the state register and capture registers; only `stall`, `fill_we` and `tag_we` are combinational.

## Test plan

- **Reset mid-fill**: assert `reset`=0 after the 2nd ack → `mem_req`, `stall`, `fill_we` and `tag_we` drop immediately, state is IDLE, no `tag_we` seen. After release, the same miss restarts at word 0.
- **Load miss, ack tied high, `req_addr`=0x1236**:
  - `stall`=1 for 5 cycles.
  - `mem_addr` = 0x1234, 0x1235, 0x1236, 0x1237.
  - `fill_we` on 4 consecutive cycles, `tag_we` with word 0x1237.
  - DONE cycle has `stall`=0.
- **Load miss with ack delayed 3 cycles per word**: `mem_addr` is held stable during each wait. The total stall is 1 + 4×4 = 17 cycles.
- **Store, `req_addr`=0x00FF, `req_wdata`=0xBEEF, hit=1**:
  - `mem_we`=1 and `mem_addr`=0x00FF until ack.
  - No `fill_we` or `tag_we`.
  - `stall` drops in DONE.
- **Load hit and `req_valid`=0**: `stall`=0 and `mem_req`=0 every cycle. Stray `mem_ack` pulses cause no state change.
- **Back-to-back accesses**: a load miss followed immediately by a store. The store is captured in the IDLE cycle after DONE, with no lost or duplicated memory request.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss/write-through sequencer.
package cache_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int LINE_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Word-index width for a line of the given size.
    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Cache stage request, memory handshake and fill-port bundle for cache_ctrl.
interface cache_ctrl_if #(parameter int ADDR_W = 16) ();

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              hit;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [15:0]       fill_data;
    logic              tag_we;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, hit, mem_ack, mem_rdata,
        output stall, mem_req, mem_we, mem_addr, mem_wdata,
        output fill_we, fill_addr, fill_data, tag_we
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, hit, mem_ack, mem_rdata,
        input  stall, mem_req, mem_we, mem_addr, mem_wdata,
        input  fill_we, fill_addr, fill_data, tag_we
    );

endinterface

// File: rtl/cache_ctrl_fill_counter.sv
// Word index within a line fill: clear on miss, increment per ack, wraps at line end.
module fill_counter
    import cache_pkg::*;
#(
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    localparam int OFF        = off_bits(LINE_WORDS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_clr,
    input  logic           i_inc,
    output logic [OFF-1:0] o_idx,
    output logic           o_last
);

    logic [OFF-1:0] r_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == OFF'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_ctrl.sv
// Load-miss line fill and store write-through sequencer; stall is combinational so the miss cycle freezes.
// Memory side holds req/addr/data until mem_ack; one unstalled DONE cycle lets the held access advance.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    cache_ctrl_if.master  bus
);

    localparam int OFF = off_bits(LINE_WORDS);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              w_start_fill;
    logic              w_start_write;
    logic              w_fill_ack;
    logic              w_last;
    logic [OFF-1:0]    w_idx;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_start_fill  = (r_state == IDLE) && bus.req_valid && !bus.req_we && !bus.hit;
    assign w_start_write = (r_state == IDLE) && bus.req_valid && bus.req_we;
    assign w_fill_ack    = (r_state == FILL) && bus.mem_ack;
    assign w_word_addr   = r_addr | ADDR_W'(w_idx);

    fill_counter #(.LINE_WORDS(LINE_WORDS)) u_fill_counter (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start_fill),
        .i_inc  (w_fill_ack),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_write)     w_next = WRITE;
                     else if (w_start_fill) w_next = FILL;
            FILL:    if (w_fill_ack && w_last) w_next = DONE;
            WRITE:   if (bus.mem_ack)          w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_addr holds the line base for a fill or the full word address for a store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start_fill) begin
            r_addr  <= {bus.req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
        end else if (w_start_write) begin
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    assign bus.mem_req   = (r_state == FILL) || (r_state == WRITE);
    assign bus.mem_we    = (r_state == WRITE);
    assign bus.mem_addr  = (r_state == FILL) ? w_word_addr : r_addr;
    assign bus.mem_wdata = r_wdata;

    // Gated by reset so a pending miss on the request inputs cannot leak a stall during reset.
    assign bus.stall = reset && (((r_state == IDLE) && bus.req_valid && (bus.req_we || !bus.hit))
                                 || (r_state == FILL) || (r_state == WRITE));

    assign bus.fill_we   = w_fill_ack;
    assign bus.fill_addr = w_word_addr;
    assign bus.fill_data = (r_state == FILL) ? bus.mem_rdata : '0;
    assign bus.tag_we    = w_fill_ack && w_last;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: expected memory/fill transactions queued by stimulus, popped by a monitor.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_if #(.ADDR_W(16)) bus ();

    cache_ctrl #(.ADDR_W(16), .LINE_WORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        tag;
    } fill_exp_t;

    mem_exp_t  mem_q[$];
    fill_exp_t fill_q[$];

    int n_chk   = 0;
    int n_fail  = 0;
    int tag_cnt = 0;
    bit ack_tie = 1'b0;
    bit stray   = 1'b0;
    int ack_dly = 0;

    function automatic logic [15:0] rd_of(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: ack after ack_dly wait cycles per word, or every cycle when tied high.
    initial begin
        int wcnt;
        wcnt          = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req) begin
                if (ack_tie || wcnt == ack_dly) begin
                    bus.mem_ack = 1'b1;
                    wcnt        = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_ack = ack_tie | stray;
                wcnt        = 0;
            end
            bus.mem_rdata = rd_of(bus.mem_addr);
        end
    end

    // Monitor: pops expectations on each accepted memory word / fill write, checks handshake hold.
    initial begin
        mem_exp_t    me;
        fill_exp_t   fe;
        logic        p_hold;
        logic        p_we;
        logic [15:0] p_addr;
        logic [15:0] p_wdata;
        p_hold = 1'b0;
        p_we = 1'b0;
        p_addr = '0;
        p_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (p_hold) begin
                    check("hold_req",   bus.mem_req,   1);
                    check("hold_we",    bus.mem_we,    p_we);
                    check("hold_addr",  bus.mem_addr,  p_addr);
                    check("hold_wdata", bus.mem_wdata, p_wdata);
                end
                if (bus.mem_req && bus.mem_ack) begin
                    if (mem_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL mem_unexpected: got addr %0h we %0b, expected no request", bus.mem_addr, bus.mem_we);
                    end else begin
                        me = mem_q.pop_front();
                        check("mem_we",   bus.mem_we,   me.we);
                        check("mem_addr", bus.mem_addr, me.addr);
                        if (me.we) check("mem_wdata", bus.mem_wdata, me.wdata);
                    end
                end
                if (bus.fill_we) begin
                    if (fill_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL fill_unexpected: got addr %0h, expected no fill", bus.fill_addr);
                    end else begin
                        fe = fill_q.pop_front();
                        check("fill_addr", bus.fill_addr, fe.addr);
                        check("fill_data", bus.fill_data, fe.data);
                        check("tag_we",    bus.tag_we,    fe.tag);
                    end
                end else if (bus.tag_we) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tag_alone: got tag_we 1 expected 0 without fill_we");
                end
                if (bus.tag_we) tag_cnt++;
                p_hold  = bus.mem_req && !bus.mem_ack;
                p_we    = bus.mem_we;
                p_addr  = bus.mem_addr;
                p_wdata = bus.mem_wdata;
            end else begin
                p_hold = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_req();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.hit       = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic push_fill(input logic [15:0] a, input int words);
        logic [15:0] base;
        base = {a[15:2], 2'b00};
        for (int i = 0; i < words; i++) begin
            mem_q.push_back('{1'b0, base | 16'(i), 16'h0});
            fill_q.push_back('{base | 16'(i), rd_of(base | 16'(i)), (i == 3)});
        end
    endtask

    // Called at posedge+1 with the request already driven; counts stall cycles up to DONE.
    task automatic count_stall(input string name, input int exp);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.stall) n++;
            else           done = 1'b1;
        end
        check(name, n, exp);
        check({name, "_done_mem_req"}, bus.mem_req, 0);
        @(posedge clk);
        #1;
        idle_req();
    endtask

    task automatic load_miss(input string name, input logic [15:0] a, input bit tie, input int dly, input int exp);
        ack_tie = tie;
        ack_dly = dly;
        push_fill(a, 4);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.hit       = 1'b0;
        bus.req_addr  = a;
        count_stall(name, exp);
    endtask

    task automatic store(input string name, input logic [15:0] a, input logic [15:0] d,
                         input bit h, input bit tie, input int dly, input int exp);
        int t0;
        ack_tie = tie;
        ack_dly = dly;
        t0      = tag_cnt;
        mem_q.push_back('{1'b1, a, d});
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.hit       = h;
        bus.req_addr  = a;
        bus.req_wdata = d;
        count_stall(name, exp);
        check({name, "_no_tag"}, tag_cnt, t0);
    endtask

    initial begin
        // Reset held with a pending miss and ack high: every output must stay low.
        idle_req();
        ack_tie       = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0010;
        repeat (2) @(negedge clk);
        check("rst_stall",   bus.stall,    0);
        check("rst_mem_req", bus.mem_req,  0);
        check("rst_mem_we",  bus.mem_we,   0);
        check("rst_addr",    bus.mem_addr, 0);
        check("rst_fill_we", bus.fill_we,  0);
        check("rst_tag_we",  bus.tag_we,   0);
        @(posedge clk);
        #1;
        idle_req();
        reset = 1'b1;
        @(posedge clk);
        #1;

        load_miss("miss_tie_stall", 16'h1236, 1'b1, 0, 5);
        load_miss("miss_dly3_stall", 16'h2A39, 1'b0, 3, 17);
        store("store_hit_stall", 16'h00FF, 16'hBEEF, 1'b1, 1'b0, 2, 4);
        store("store_miss_stall", 16'h0400, 16'h0F0F, 1'b0, 1'b1, 0, 2);

        // Hits and idle cycles with stray acks: no stall, no request.
        ack_tie = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = i[0];
            bus.req_we    = 1'b0;
            bus.hit       = 1'b1;
            bus.req_addr  = 16'h3000 + 16'(i);
            stray         = ~i[1];
            @(negedge clk);
            check("hit_stall",   bus.stall,   0);
            check("hit_mem_req", bus.mem_req, 0);
            @(posedge clk);
            #1;
        end
        stray = 1'b0;
        idle_req();
        @(posedge clk);
        #1;

        // Back-to-back: store captured in the IDLE cycle right after the fill's DONE.
        load_miss("b2b_miss_stall", 16'h0101, 1'b1, 0, 5);
        store("b2b_store_stall", 16'h0203, 16'h1234, 1'b0, 1'b1, 0, 2);

        // Reset after the second fill word: everything drops, no tag, miss restarts at word 0.
        begin
            int t0;
            t0 = tag_cnt;
            ack_tie = 1'b1;
            push_fill(16'h0042, 2);
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.hit       = 1'b0;
            bus.req_addr  = 16'h0042;
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b0;
            #1;
            check("mid_rst_mem_req", bus.mem_req, 0);
            check("mid_rst_stall",   bus.stall,   0);
            check("mid_rst_fill_we", bus.fill_we, 0);
            check("mid_rst_tag_we",  bus.tag_we,  0);
            check("mid_rst_state",   dut.r_state, IDLE);
            repeat (2) @(posedge clk);
            #1;
            check("mid_rst_no_tag",    tag_cnt,       t0);
            check("mid_rst_mem_drain", mem_q.size(),  0);
            check("mid_rst_fill_drain", fill_q.size(), 0);
            push_fill(16'h0042, 4);
            reset = 1'b1;
            count_stall("restart_stall", 5);
        end

        repeat (3) @(posedge clk);
        check("final_mem_q",  mem_q.size(),  0);
        check("final_fill_q", fill_q.size(), 0);
        check("final_tags",   tag_cnt,       4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
